// File: rtl/intr_pkg.sv
// Shared constants for the interrupt controller: register map, CTRL layout, cause codes.
// Also provides the lowest-set-bit cause encoder used by the top level.
package intr_pkg;

    localparam int unsigned OFF_PEND = 0;
    localparam int unsigned OFF_MASK = 2;
    localparam int unsigned OFF_MODE = 4;
    localparam int unsigned OFF_CTRL = 6;
    localparam int unsigned OFF_SII  = 8;

    localparam int CTRL_IE    = 0;
    localparam int CTRL_CM    = 1;
    localparam int CTRL_DEPTH = 2;
    localparam int CTRL_OVF   = 5;
    localparam int CTRL_UNF   = 6;

    localparam logic [3:0] INTNUM_ILLEGAL = 4'h0;
    localparam logic [3:0] INTNUM_NONE    = 4'hF;

    // Channel i maps to cause i+1; cause 0 is reserved for the illegal-instruction trap.
    function automatic logic [3:0] first_cause(input logic [13:0] v);
        first_cause = INTNUM_NONE;
        for (int i = 13; i >= 0; i--) begin
            if (v[i]) first_cause = 4'(i + 1);
        end
    endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// Register-bus request side of the interrupt controller (address, strobes, write data).
// Single-cycle access, no wait states; the tri-state read bus stays a plain port.
interface intr_ctrl_if #(
    parameter int DBITS = 16,
    parameter int ABITS = 16
) ();
    logic [ABITS-1:0] ABUS;
    logic             RE;
    logic             WE;
    logic [DBITS-1:0] WBUS;

    modport master (output ABUS, output RE, output WE, output WBUS);
    modport slave  (input  ABUS, input  RE, input  WE, input  WBUS);
endinterface

// File: rtl/intr_stack.sv
// LIFO of saved {IE,CM} pairs for nested interrupts; push/pop take effect on the clock edge.
// Push when full and pop when empty are ignored; the caller flags overflow/underflow.
module intr_stack #(
    parameter int NEST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [1:0] din,
    output logic [1:0] dout,
    output logic [2:0] depth,
    output logic       full,
    output logic       empty
);
    // Sized for the largest legal NEST so a 3-bit depth indexes it exactly.
    logic [1:0] mem [8];

    assign full  = (depth == 3'(NEST));
    assign empty = (depth == 3'd0);
    assign dout  = empty ? 2'b00 : mem[depth - 3'd1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth <= 3'd0;
            for (int i = 0; i < 8; i++) mem[i] <= 2'b00;
        end else if (push && !full) begin
            mem[depth] <= din;
            depth      <= depth + 3'd1;
        end else if (pop && !empty) begin
            depth <= depth - 3'd1;
        end
    end
endmodule

// File: rtl/intr_ctrl.sv
// Vectored interrupt controller with maskable edge/level channels and a nesting stack.
// Request/cause are combinational; register and ack/return updates land on the next CLK edge.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int               DBITS = 16,
    parameter int               ABITS = 16,
    parameter int               NCH   = 8,
    parameter int               NEST  = 4,
    parameter logic [ABITS-1:0] RBASE = 16'hFFD0
) (
    input  logic             CLK,
    input  logic             RESET_N,
    intr_ctrl_if.slave       bus,
    inout  wire  [DBITS-1:0] RBUS,
    input  logic [NCH-1:0]   IRQ,
    input  logic             IINST,
    input  logic             INTACK,
    input  logic             RETI,
    output logic             INTREQ,
    output logic [3:0]       INTNUM,
    output logic             IE,
    output logic             CM
);
    localparam logic [ABITS-1:0] A_PEND = ABITS'(RBASE + OFF_PEND);
    localparam logic [ABITS-1:0] A_MASK = ABITS'(RBASE + OFF_MASK);
    localparam logic [ABITS-1:0] A_MODE = ABITS'(RBASE + OFF_MODE);
    localparam logic [ABITS-1:0] A_CTRL = ABITS'(RBASE + OFF_CTRL);
    localparam logic [ABITS-1:0] A_SII  = ABITS'(RBASE + OFF_SII);

    logic [NCH-1:0]   irq_q, irq_p, pend, pend_nxt, mask, mode, ack_clr, pm;
    logic             ie_q, cm_q, ovf, unf;
    logic [3:0]       sii, intnum;
    logic [2:0]       depth;
    logic [1:0]       top;
    logic             full, empty, ack, reti_go;
    logic             wr_pend, wr_mask, wr_mode, wr_ctrl;
    logic             rd_hit;
    logic [DBITS-1:0] rd_dat;

    assign pm     = pend & mask;
    assign intnum = IINST ? INTNUM_ILLEGAL : first_cause(14'(pm));
    assign INTREQ = IINST | (ie_q & |pm);
    assign INTNUM = intnum;
    assign IE     = ie_q;
    assign CM     = cm_q;

    assign ack     = INTACK & INTREQ;
    assign reti_go = RETI & ~ack;

    assign wr_pend = bus.WE && (bus.ABUS == A_PEND);
    assign wr_mask = bus.WE && (bus.ABUS == A_MASK);
    assign wr_mode = bus.WE && (bus.ABUS == A_MODE);
    assign wr_ctrl = bus.WE && (bus.ABUS == A_CTRL);

    intr_stack #(.NEST(NEST)) u_stack (
        .clk   (CLK),
        .rst_n (RESET_N),
        .push  (ack),
        .pop   (reti_go),
        .din   ({ie_q, cm_q}),
        .dout  (top),
        .depth (depth),
        .full  (full),
        .empty (empty)
    );

    // Clear order matters: W1C and ack-clear first, then edge sets win, then level channels follow the sample.
    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NCH; i++) begin
            if (intnum == 4'(i + 1)) ack_clr[i] = mode[i];
        end
        pend_nxt = pend;
        if (wr_pend) pend_nxt = pend_nxt & ~bus.WBUS[NCH-1:0];
        if (ack)     pend_nxt = pend_nxt & ~ack_clr;
        pend_nxt = pend_nxt | (irq_q & ~irq_p & mode);
        pend_nxt = (pend_nxt & mode) | (irq_q & ~mode);
    end

    always_comb begin
        rd_hit = bus.RE;
        rd_dat = '0;
        case (bus.ABUS)
            A_PEND: rd_dat[NCH-1:0] = pend;
            A_MASK: rd_dat[NCH-1:0] = mask;
            A_MODE: rd_dat[NCH-1:0] = mode;
            A_CTRL: begin
                rd_dat[CTRL_IE]          = ie_q;
                rd_dat[CTRL_CM]          = cm_q;
                rd_dat[CTRL_DEPTH +: 3]  = depth;
                rd_dat[CTRL_OVF]         = ovf;
                rd_dat[CTRL_UNF]         = unf;
            end
            A_SII:   rd_dat[3:0] = sii;
            default: rd_hit = 1'b0;
        endcase
    end

    assign RBUS = rd_hit ? rd_dat : 'z;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            irq_q <= '0;
            irq_p <= '0;
            pend  <= '0;
            mask  <= '0;
            mode  <= '1;
            ie_q  <= 1'b0;
            cm_q  <= 1'b1;
            ovf   <= 1'b0;
            unf   <= 1'b0;
            sii   <= 4'h0;
        end else begin
            irq_q <= IRQ;
            irq_p <= irq_q;
            pend  <= pend_nxt;
            if (wr_mask) mask <= bus.WBUS[NCH-1:0];
            if (wr_mode) mode <= bus.WBUS[NCH-1:0];
            if (wr_ctrl && bus.WBUS[CTRL_OVF]) ovf <= 1'b0;
            if (wr_ctrl && bus.WBUS[CTRL_UNF]) unf <= 1'b0;
            // Hardware events outrank software CTRL writes to IE/CM.
            if (ack) begin
                ie_q <= 1'b0;
                cm_q <= 1'b1;
                sii  <= intnum;
                if (full) ovf <= 1'b1;
            end else if (reti_go) begin
                if (empty) begin
                    unf <= 1'b1;
                end else begin
                    ie_q <= top[1];
                    cm_q <= top[0];
                end
            end else if (wr_ctrl) begin
                ie_q <= bus.WBUS[CTRL_IE];
                cm_q <= bus.WBUS[CTRL_CM];
            end
        end
    end
endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 SHALL have parameter DBITS, default 16, data/bus width.
REQ-002 SHALL have parameter ABITS, default 16, address width.
REQ-003 SHALL have parameter NCH, default 8, external interrupt channels (1..14).
REQ-004 SHALL have parameter NEST, default 4, nesting-stack depth (1..7).
REQ-005 SHALL have parameter RBASE, default 16'hFFD0, register-block base address.
REQ-006 SHALL have one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port CLK input 1: the single clock, rising edge.
REQ-008 SHALL have port RESET_N input 1: asynchronous active-low reset.
REQ-009 SHALL have port ABUS input ABITS: bus address.
REQ-010 SHALL have port RBUS inout DBITS: tri-state read bus.
REQ-011 SHALL have port RE input 1: bus read strobe.
REQ-012 SHALL have port WE input 1: bus write strobe.
REQ-013 SHALL have port WBUS input DBITS: bus write data.
REQ-014 SHALL have port IRQ input NCH: device interrupt lines.
REQ-015 SHALL have port IINST input 1: illegal instruction/privilege fault from the pipeline.
REQ-016 SHALL have port INTACK input 1: processor takes the request (flush and vector).
REQ-017 SHALL have port RETI input 1: RETI retired.
REQ-018 SHALL have port INTREQ output 1: interrupt request.
REQ-019 SHALL have port INTNUM output 4: cause number.
REQ-020 SHALL have ports IE and CM, each output 1: current interrupt enable and current mode.

Function
REQ-021 Registers (word offsets from RBASE) SHALL be: +0 PEND (read, write-1-to-clear); +2 MASK (RW); +4 MODE (RW, bit=1 edge, 0 level); +6 CTRL (bit0 IE RW, bit1 CM RW, bits4:2 depth RO, bit5 OVF W1C, bit6 UNF W1C); +8 SII (RO).
REQ-022 RBUS SHALL be driven combinationally only when RE and ABUS hits a register; it SHALL be z otherwise, and unused bits read 0.
REQ-023 Bus writes SHALL take effect on the CLK edge where WE and the address hit.
REQ-024 IRQ SHALL be registered once; in edge mode a 0->1 transition of the registered sample SHALL set PEND[i]; in level mode PEND[i] SHALL equal the registered sample.
REQ-025 INTREQ SHALL be combinational: IINST OR (IE AND |(PEND & MASK)).
REQ-026 INTNUM SHALL be 0 when IINST=1, else 1 + the lowest-indexed set bit of PEND & MASK, else 4'hF.
REQ-027 On INTACK with INTREQ=1: push {IE,CM}; IE<=0; CM<=1; depth+1; SII<=INTNUM; clear PEND[INTNUM-1] if that channel is edge mode. All SHALL complete in the same edge.
REQ-028 INTACK without INTREQ SHALL be ignored.
REQ-029 A push at depth==NEST SHALL not store, SHALL set OVF, and SHALL still apply IE<=0 and CM<=1.
REQ-030 On RETI: pop into IE and CM; depth-1. At depth 0, RETI SHALL set UNF and leave IE and CM unchanged.
REQ-031 INTACK and RETI in the same cycle: INTACK SHALL win and RETI SHALL be dropped (no UNF).
REQ-032 An edge set and a W1C clear of the same PEND bit in the same cycle: set SHALL win.
REQ-033 INTACK and a bus write to CTRL in the same cycle: INTACK updates to IE and CM SHALL win.

Reset
REQ-034 On RESET_N low, the following SHALL be reset: PEND=0, MASK=0, MODE=all ones, IE=0, CM=1, depth=0, OVF=UNF=0, SII=0, IRQ sample=0, stack contents=0.
REQ-035 During reset, INTREQ SHALL equal IINST.

Structure
REQ-036 Package intr_pkg SHALL hold register offsets, CTRL bit positions, INTNUM_ILLEGAL=0 and INTNUM_NONE=4'hF.
REQ-037 Sub-module intr_stack SHALL be a NEST-deep LIFO of 2-bit {IE,CM} entries with push, pop, depth, full and empty signals.

Verification
REQ-038 Setup MASK=0x0C, IE=1; pulse IRQ[2] and IRQ[3] together -> INTREQ=1, INTNUM=3; after INTACK, INTNUM=4, IE=0, CM=1, SII=3.
REQ-039 IINST=1 with PEND&MASK!=0 -> INTNUM=0; INTACK -> SII=0, PEND unchanged.
REQ-040 Nest five INTACKs with NEST=4, setting IE=1 between each -> depth=4, OVF=1; four RETIs restore the saved IE/CM in LIFO order; a fifth RETI -> UNF=1.
REQ-041 Level-mode channel: hold IRQ high through INTACK -> PEND stays 1; drop IRQ -> PEND=0 two edges later.
REQ-042 Same-cycle edge plus W1C of that bit -> PEND=1; RESET_N low mid-nest -> all values per REQ-034 immediately.
